// File: rtl/cnu_msg_expand_pkg.sv
// -----------------------------------------------------------------------------
// cnu_msg_expand_pkg
// Shared constants and types for the check-node message expander.
//   QUAN_SIZE_DEF / CN_DEGREE_DEF : default magnitude width and maximum degree
//   IDX_W                         : width of min index and edge index
//   DEG6                          : reduced check-node degree
//   state_e                       : expander FSM states
//   rec_width()                   : packed record width
//                                   {min1, min2, min_index, sign, deg6}
// -----------------------------------------------------------------------------
package cnu_msg_expand_pkg;

  localparam int QUAN_SIZE_DEF = 4;
  localparam int CN_DEGREE_DEF = 8;

  localparam int IDX_W = 3;
  localparam int DEG6  = 6;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  function automatic int rec_width(input int quan_size, input int cn_degree);
    return 2 * quan_size + IDX_W + cn_degree + 1;
  endfunction

endpackage

// File: rtl/cnu_rec_fifo.sv
// -----------------------------------------------------------------------------
// cnu_rec_fifo
// Two-entry FIFO holding compressed check-node records. Push and pop in the
// same cycle both take effect. The caller never pushes while full.
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset (empties the FIFO)
//   push_i   in   write data_i
//   pop_i    in   drop the head entry
//   data_i   in   record to write
//   head_o   out  oldest record
//   next_o   out  record behind the head (meaningful when count_o == 2)
//   count_o  out  number of stored records (0..2)
// -----------------------------------------------------------------------------
module cnu_rec_fifo
  import cnu_msg_expand_pkg::*;
#(
  parameter int W = rec_width(QUAN_SIZE_DEF, CN_DEGREE_DEF)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] head_o,
  output logic [W-1:0] next_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;

  // Payload storage needs no reset: count_q decides what is valid.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign next_o  = mem_q[~rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/cnu_msg_expand.sv
// -----------------------------------------------------------------------------
// cnu_msg_expand
// Check-node message expander: takes compressed CNU records
// {min1, min2, min_index, sign, deg6} and emits one extrinsic message per edge
// per cycle. A 2-entry record FIFO decouples the min-finder from the stream.
// Optional feature macro: CNU_OFFSET_EN -- when defined, each output magnitude
// is reduced by OFFSET, saturating at 0.
// Ports:
//   sys_clk, rstn        clock, asynchronous active-low reset
//   in_valid/in_ready    record handshake (in_ready = FIFO not full)
//   in_min1, in_min2     smallest / second-smallest magnitude
//   in_min_index         edge holding min1
//   in_sign              per-edge input signs (bit i = edge i)
//   in_deg6              1: degree 6, 0: degree CN_DEGREE
//   out_valid/out_ready  message handshake
//   out_mag, out_sign    extrinsic magnitude / sign for out_edge
//   out_edge             edge index, out_last marks final edge of a record
// -----------------------------------------------------------------------------
module cnu_msg_expand
  import cnu_msg_expand_pkg::*;
#(
  parameter int QUAN_SIZE = QUAN_SIZE_DEF,
  parameter int CN_DEGREE = CN_DEGREE_DEF,
  parameter int OFFSET    = 1
) (
  input  logic                 sys_clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [QUAN_SIZE-1:0] in_min1,
  input  logic [QUAN_SIZE-1:0] in_min2,
  input  logic [IDX_W-1:0]     in_min_index,
  input  logic [CN_DEGREE-1:0] in_sign,
  input  logic                 in_deg6,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [QUAN_SIZE-1:0] out_mag,
  output logic                 out_sign,
  output logic [IDX_W-1:0]     out_edge,
  output logic                 out_last
);

  localparam int REC_W = rec_width(QUAN_SIZE, CN_DEGREE);

`ifdef CNU_OFFSET_EN
  localparam logic [QUAN_SIZE-1:0] OFF_AMT = QUAN_SIZE'(OFFSET);
`else
  // Zero amount turns the saturating stage below into a pass-through.
  localparam logic [QUAN_SIZE-1:0] OFF_AMT = QUAN_SIZE'(OFFSET * 0);
`endif

  // Message for edge e of a record, packed as {mag, sign, last}.
  function automatic logic [QUAN_SIZE+1:0] edge_msg(input logic [REC_W-1:0] rec,
                                                    input logic [IDX_W-1:0] e);
    logic [QUAN_SIZE-1:0] min1;
    logic [QUAN_SIZE-1:0] min2;
    logic [QUAN_SIZE-1:0] mag;
    logic [IDX_W-1:0]     idx;
    logic [CN_DEGREE-1:0] sgn;
    logic                 deg6;
    logic                 s_tot;
    logic [IDX_W-1:0]     d_last;
    {min1, min2, idx, sgn, deg6} = rec;
    d_last = deg6 ? IDX_W'(DEG6 - 1) : IDX_W'(CN_DEGREE - 1);
    // Total sign over active edges only; bits beyond the degree are ignored.
    s_tot = 1'b0;
    for (int i = 0; i < CN_DEGREE; i++) begin
      if (!deg6 || i < DEG6) begin
        s_tot = s_tot ^ sgn[i];
      end
    end
    // An out-of-range min index never matches, so every edge gets min1.
    mag = (e == idx) ? min2 : min1;
    mag = (mag > OFF_AMT) ? (mag - OFF_AMT) : '0;
    return {mag, s_tot ^ sgn[e], (e == d_last)};
  endfunction

  logic [REC_W-1:0] in_rec;
  logic [REC_W-1:0] head_rec;
  logic [REC_W-1:0] next_rec;
  logic [REC_W-1:0] load_rec;
  logic [1:0]       fifo_count;
  logic             push;
  logic             pop;
  logic             fire;
  logic             load;
  logic [IDX_W-1:0] load_edge;
  logic [QUAN_SIZE+1:0] msg;

  state_e               state_q,     state_d;
  logic                 out_valid_q, out_valid_d;
  logic [QUAN_SIZE-1:0] out_mag_q,   out_mag_d;
  logic                 out_sign_q,  out_sign_d;
  logic [IDX_W-1:0]     out_edge_q,  out_edge_d;
  logic                 out_last_q,  out_last_d;

  assign in_rec   = {in_min1, in_min2, in_min_index, in_sign, in_deg6};
  assign in_ready = (fifo_count < 2'd2);
  assign push     = in_valid & in_ready;
  assign fire     = out_valid_q & out_ready;

  cnu_rec_fifo #(
    .W(REC_W)
  ) u_fifo (
    .clk     (sys_clk),
    .rst_n   (rstn),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (in_rec),
    .head_o  (head_rec),
    .next_o  (next_rec),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_mag_d   = out_mag_q;
    out_sign_d  = out_sign_q;
    out_edge_d  = out_edge_q;
    out_last_d  = out_last_q;
    pop         = 1'b0;
    load        = 1'b0;
    load_rec    = head_rec;
    load_edge   = '0;
    case (state_q)
      ST_IDLE: begin
        // FIFO is empty here; bypass the incoming record for 1-cycle latency.
        if (push) begin
          load     = 1'b1;
          load_rec = in_rec;
          state_d  = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (fire) begin
          if (!out_last_q) begin
            load      = 1'b1;
            load_edge = out_edge_q + IDX_W'(1);
          end else begin
            pop = 1'b1;
            // Next record is either already buffered behind the head, or
            // arriving this very cycle into a FIFO that holds only the head.
            if (fifo_count == 2'd2) begin
              load     = 1'b1;
              load_rec = next_rec;
            end else if (push) begin
              load     = 1'b1;
              load_rec = in_rec;
            end else begin
              state_d     = ST_IDLE;
              out_valid_d = 1'b0;
              out_mag_d   = '0;
              out_sign_d  = 1'b0;
              out_edge_d  = '0;
              out_last_d  = 1'b0;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    msg = edge_msg(load_rec, load_edge);
    if (load) begin
      out_valid_d = 1'b1;
      {out_mag_d, out_sign_d, out_last_d} = msg;
      out_edge_d  = load_edge;
    end
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_mag_q   <= '0;
      out_sign_q  <= 1'b0;
      out_edge_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_mag_q   <= out_mag_d;
      out_sign_q  <= out_sign_d;
      out_edge_q  <= out_edge_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_mag   = out_mag_q;
  assign out_sign  = out_sign_q;
  assign out_edge  = out_edge_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_cnu_msg_expand.sv
// -----------------------------------------------------------------------------
// tb_cnu_msg_expand
// Scoreboard bench for cnu_msg_expand. Expected per-edge messages are queued
// when a record is accepted and compared as the DUT hands each message off.
// Honours CNU_OFFSET_EN the same way the design does (OFFSET = 1).
// -----------------------------------------------------------------------------
module tb_cnu_msg_expand;

  localparam int Q   = 4;
  localparam int C   = 8;
  localparam int OFS = 1;

  logic         sys_clk = 1'b0;
  logic         rstn = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [Q-1:0] in_min1 = '0;
  logic [Q-1:0] in_min2 = '0;
  logic [2:0]   in_min_index = '0;
  logic [C-1:0] in_sign = '0;
  logic         in_deg6 = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [Q-1:0] out_mag;
  logic         out_sign;
  logic [2:0]   out_edge;
  logic         out_last;

  cnu_msg_expand #(
    .QUAN_SIZE(Q),
    .CN_DEGREE(C),
    .OFFSET   (OFS)
  ) dut (
    .sys_clk      (sys_clk),
    .rstn         (rstn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_min1      (in_min1),
    .in_min2      (in_min2),
    .in_min_index (in_min_index),
    .in_sign      (in_sign),
    .in_deg6      (in_deg6),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_mag      (out_mag),
    .out_sign     (out_sign),
    .out_edge     (out_edge),
    .out_last     (out_last)
  );

  always #5 sys_clk = ~sys_clk;

  // {mag, sign, edge, last}
  typedef logic [Q+4:0] exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // monitor bookkeeping
  logic   mon_en       = 1'b0;
  int     hs_cnt       = 0;
  int     first_hs_cyc = -1;
  int     prev_hs_cyc  = -1;
  int     last_end_cyc = -1;
  int     gap_cnt      = 0;
  logic   stall_pend   = 1'b0;
  logic [Q+5:0] snap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: expected message list for one record.
  function automatic void push_expected(input logic [Q-1:0] m1, input logic [Q-1:0] m2,
                                        input logic [2:0] idx, input logic [C-1:0] sg,
                                        input logic d6);
    int           d;
    logic         s;
    logic [Q-1:0] m;
    d = d6 ? 6 : C;
    s = 1'b0;
    for (int i = 0; i < d; i++) s = s ^ sg[i];
    for (int e = 0; e < d; e++) begin
      m = (e == int'(idx)) ? m2 : m1;
`ifdef CNU_OFFSET_EN
      m = (m >= Q'(OFS)) ? (m - Q'(OFS)) : '0;
`endif
      sb_q.push_back({m, s ^ sg[e], 3'(e), (e == d - 1)});
    end
  endfunction

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_rec(input logic [Q-1:0] m1, input logic [Q-1:0] m2,
                          input logic [2:0] idx, input logic [C-1:0] sg, input logic d6,
                          output int acc_cyc, output logic first_ready);
    in_valid = 1'b1; in_min1 = m1; in_min2 = m2;
    in_min_index = idx; in_sign = sg; in_deg6 = d6;
    @(negedge sys_clk);
    first_ready = in_ready;
    for (int i = 0; i < 300 && !in_ready; i++) @(negedge sys_clk);
    acc_cyc = cyc;
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    else push_expected(m1, m2, idx, sg, d6);
    @(posedge sys_clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(negedge sys_clk);
    @(negedge sys_clk);
    check("drain_left", 32'(sb_q.size()), 32'd0);
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_stats();
    hs_cnt = 0; first_hs_cyc = -1; prev_hs_cyc = -1; gap_cnt = 0;
  endtask

  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  // Monitor: compare each handed-off message, check outputs hold during stalls.
  initial forever begin
    exp_t e;
    @(negedge sys_clk);
    if (mon_en) begin
      if (stall_pend) begin
        check("stall_hold", 32'({out_valid, out_mag, out_sign, out_edge, out_last}), 32'(snap));
        stall_pend = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_msg", 32'(out_valid), 32'd0);
        end else begin
          e = sb_q.pop_front();
          $display("msg edge=%0d mag=%0d sign=%0d last=%0d (cyc %0d)",
                   out_edge, out_mag, out_sign, out_last, cyc);
          check("msg", 32'({out_mag, out_sign, out_edge, out_last}), 32'(e));
        end
        if (first_hs_cyc < 0) first_hs_cyc = cyc;
        if (prev_hs_cyc >= 0 && cyc != prev_hs_cyc + 1) gap_cnt++;
        prev_hs_cyc = cyc;
        hs_cnt++;
        if (out_last) last_end_cyc = cyc;
      end else if (out_valid && !out_ready) begin
        snap = {out_valid, out_mag, out_sign, out_edge, out_last};
        stall_pend = 1'b1;
      end
    end
  end

  initial begin
    int   acc_a, acc_b, acc_c, base;
    logic rdy_a, rdy_b, rdy_c;

    // Reset state
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_mag", 32'(out_mag), 32'd0);
    check("rst_sign", 32'(out_sign), 32'd0);
    check("rst_edge", 32'(out_edge), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (3) @(negedge sys_clk);
    rstn = 1'b1;
    mon_en = 1'b1;
    @(posedge sys_clk);
    #1;

    // Degree 8 basic record
    send_rec(4'd2, 4'd5, 3'd3, 8'b0000_0101, 1'b0, acc_a, rdy_a);
    drain();

    // Degree 6, high sign bits must be ignored
    send_rec(4'd1, 4'd7, 3'd5, 8'b1100_0001, 1'b1, acc_a, rdy_a);
    drain();

    // Three back-to-back records, continuous output
    clear_stats();
    send_rec(4'd3, 4'd9, 3'd0, 8'b1011_0110, 1'b0, acc_a, rdy_a);
    send_rec(4'd4, 4'd6, 3'd7, 8'b0110_1001, 1'b0, acc_b, rdy_b);
    send_rec(4'd1, 4'd2, 3'd4, 8'b1111_0000, 1'b0, acc_c, rdy_c);
    check("latency_first_edge", 32'(first_hs_cyc), 32'(acc_a + 1));
    check("in_ready_second", 32'(rdy_b), 32'd1);
    check("in_ready_full", 32'(rdy_c), 32'd0);
    check("third_accept_cycle", 32'(acc_c), 32'(last_end_cyc + 1));
    drain();
    check("b2b_count", 32'(hs_cnt), 32'd24);
    check("b2b_gaps", 32'(gap_cnt), 32'd0);

    // Stall mid-record: ready 1,0,0,1
    send_rec(4'd5, 4'd8, 3'd2, 8'b1000_1110, 1'b0, acc_a, rdy_a);
    @(posedge sys_clk); #1;
    out_ready = 1'b1; @(posedge sys_clk); #1;
    out_ready = 1'b0; @(posedge sys_clk); #1;
    out_ready = 1'b0; @(posedge sys_clk); #1;
    out_ready = 1'b1;
    drain();

    // Out-of-range min index on a degree-6 record
    send_rec(4'd3, 4'd12, 3'd7, 8'b0010_1010, 1'b1, acc_a, rdy_a);
    drain();

    // Zero magnitude (saturation case when the offset is enabled)
    send_rec(4'd0, 4'd3, 3'd2, 8'b0101_0011, 1'b0, acc_a, rdy_a);
    drain();

    // Reset mid-record with a second record buffered
    send_rec(4'd2, 4'd4, 3'd6, 8'b0001_1000, 1'b0, acc_a, rdy_a);
    send_rec(4'd6, 4'd7, 3'd1, 8'b1110_0111, 1'b0, acc_b, rdy_b);
    for (int i = 0; i < 50 && !(out_valid && out_edge == 3'd4); i++) @(negedge sys_clk);
    check("edge4_reached", 32'(out_edge), 32'd4);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_mag", 32'(out_mag), 32'd0);
    check("arst_edge", 32'(out_edge), 32'd0);
    check("arst_last", 32'(out_last), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    sb_q.delete();
    repeat (2) @(negedge sys_clk);
    rstn = 1'b1;
    base = hs_cnt;
    repeat (20) @(negedge sys_clk);
    check("no_residual", 32'(hs_cnt - base), 32'd0);
    @(posedge sys_clk); #1;

    // Recovery after reset
    send_rec(4'd7, 4'd9, 3'd0, 8'b0100_0010, 1'b1, acc_a, rdy_a);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
